// File: rtl/checksum_accum.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : checksum_accum
// Brief    : Accumulates 4-bit nibbles into a ones'-complement sum per packet
//            and presents sum, checksum, nibble count and truncation flag
//            through a valid/ready result port.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module checksum_accum #(
   parameter int MAX_LEN = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] in_data_i,
   input  logic       in_last_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [3:0] out_sum_o,
   output logic [3:0] out_check_o,
   output logic [3:0] out_count_o,
   output logic       out_err_o
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_LEN);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t     state_q;
   logic [3:0] acc_q;
   logic [3:0] count_q;
   logic       err_q;
   logic       in_ready_q;
   logic       out_valid_q;

   logic [4:0] sum5_d;
   logic [3:0] acc_d;
   logic [3:0] count_d;
   logic       in_xfer_d;
   logic       out_xfer_d;
   logic       at_max_d;

   // Next accumulator and count for a nibble transfer; end-around carry folded
   // back in, the carry of that second add is dropped (0xF is kept as-is).
   always_comb begin
      sum5_d     = {1'b0, acc_q} + {1'b0, in_data_i};
      acc_d      = sum5_d[3:0] + {3'b000, sum5_d[4]};
      count_d    = count_q + 4'd1;
      in_xfer_d  = in_valid_i & in_ready_q;
      out_xfer_d = out_valid_q & out_ready_i;
      at_max_d   = (count_d == MAX_CNT);
   end

   // Packet state machine with registered handshake flags and result fields.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= 4'h0;
         count_q     <= 4'h0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (in_xfer_d) begin
                  acc_q   <= acc_d;
                  count_q <= count_d;
                  if (in_last_i || at_max_d) begin
                     // Truncation only when the length limit, not in_last,
                     // closed the packet.
                     state_q     <= S_DONE;
                     err_q       <= ~in_last_i;
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= S_ACCUM;
                  end
               end
            end
            S_DONE: begin
               if (out_xfer_d) begin
                  state_q     <= S_IDLE;
                  acc_q       <= 4'h0;
                  count_q     <= 4'h0;
                  err_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               acc_q       <= 4'h0;
               count_q     <= 4'h0;
               err_q       <= 1'b0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Result fields come straight from the state registers; acc and count are
   // frozen in DONE, so they stay stable while out_valid is high.
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_sum_o   = acc_q;
   assign out_check_o = ~acc_q;
   assign out_count_o = count_q;
   assign out_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_checksum_accum.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_checksum_accum
// Brief    : Directed self-checking bench for checksum_accum (MAX_LEN = 8).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_checksum_accum;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic [3:0] out_check;
   logic [3:0] out_count;
   logic       out_err;

   int n_err = 0;
   int n_chk = 0;

   checksum_accum #(.MAX_LEN(8)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_check_o (out_check),
      .out_count_o (out_count),
      .out_err_o   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d, input logic l);
      check("send_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [3:0] s, input logic [3:0] c,
                               input logic [3:0] n, input logic e);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"},   32'(out_sum),   32'(s));
      check({tag, "_check"}, 32'(out_check), 32'(c));
      check({tag, "_count"}, 32'(out_count), 32'(n));
      check({tag, "_err"},   32'(out_err),   32'(e));
      check({tag, "_inrdy"}, 32'(in_ready),  32'd0);
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_rel_inrdy"}, 32'(in_ready),  32'd1);
      check({tag, "_rel_count"}, 32'(out_count), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;     // must be ignored while reset is active
      in_data   = 4'h5;
      in_last   = 1'b1;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum",   32'(out_sum),   32'h0);
      check("rst_check", 32'(out_check), 32'hF);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_err",   32'(out_err),   32'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b1;
      tick();
      check("rst_inrdy", 32'(in_ready),  32'd1);
      check("rst_idle",  32'(out_valid), 32'd0);

      // out_ready with nothing pending does nothing
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_ordy_valid", 32'(out_valid), 32'd0);
      check("idle_ordy_inrdy", 32'(in_ready),  32'd1);

      // 3 + 4 = 7
      send(4'h3, 1'b0);
      check("p1_mid_valid", 32'(out_valid), 32'd0);
      send(4'h4, 1'b1);
      check_result("p1", 4'h7, 4'h8, 4'd2, 1'b0);
      release_out("p1");

      // 9 + 8 = 0x11 -> end-around carry -> 2
      send(4'h9, 1'b0);
      send(4'h8, 1'b1);
      check_result("p2", 4'h2, 4'hD, 4'd2, 1'b0);
      release_out("p2");

      // F + F -> F (no normalisation of negative zero)
      send(4'hF, 1'b0);
      send(4'hF, 1'b1);
      check_result("p3", 4'hF, 4'h0, 4'd2, 1'b0);
      release_out("p3");

      // single zero nibble
      send(4'h0, 1'b1);
      check_result("p4", 4'h0, 4'hF, 4'd1, 1'b0);
      release_out("p4");

      // backpressure: result held, A waits
      send(4'h1, 1'b1);
      in_valid = 1'b1;
      in_data  = 4'hA;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_result("hold", 4'h1, 4'hE, 4'd1, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_rel_valid", 32'(out_valid), 32'd0);
      check("hold_rel_inrdy", 32'(in_ready),  32'd1);
      check("hold_rel_count", 32'(out_count), 32'd0);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_result("pA", 4'hA, 4'h5, 4'd1, 1'b0);
      release_out("pA");

      // eight 1s without last -> truncated at MAX_LEN
      in_valid = 1'b1;
      in_data  = 4'h1;
      in_last  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("max_inrdy", 32'(in_ready), 32'd1);
         tick();
      end
      check_result("max", 4'h8, 4'h7, 4'd8, 1'b1);
      tick();
      tick();
      check_result("max_wait", 4'h8, 4'h7, 4'd8, 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("max_rel_valid", 32'(out_valid), 32'd0);
      check("max_rel_count", 32'(out_count), 32'd0);
      tick();   // 9th nibble accepted now
      check("ninth_count", 32'(out_count), 32'd1);
      check("ninth_sum",   32'(out_sum),   32'h1);
      check("ninth_valid", 32'(out_valid), 32'd0);
      in_data = 4'h2;
      in_last = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_result("ninth_pkt", 4'h3, 4'hC, 4'd2, 1'b0);
      release_out("ninth");

      // last on the MAX_LEN-th nibble -> no error
      for (int i = 0; i < 7; i++) send(4'h2, 1'b0);
      send(4'h2, 1'b1);
      check_result("maxlast", 4'h1, 4'hE, 4'd8, 1'b0);   // 16 -> 0x10 -> 1
      release_out("maxlast");

      // reset mid-packet discards partial sum
      send(4'h5, 1'b0);
      send(4'h6, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_count", 32'(out_count), 32'd0);
      check("midrst_sum",   32'(out_sum),   32'h0);
      send(4'h5, 1'b1);
      check_result("midrst", 4'h5, 4'hA, 4'd1, 1'b0);

      // reset in DONE drops the pending result
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("donerst_valid", 32'(out_valid), 32'd0);
      check("donerst_sum",   32'(out_sum),   32'h0);
      check("donerst_inrdy", 32'(in_ready),  32'd1);
      tick();
      check("donerst_stale", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/checksum_accum.md
CHECKSUM_ACCUM -- requirements
Module: checksum_accum

Interface
REQ-001 Parameter: MAX_LEN, default 8, maximum number of nibbles per packet; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: in_valid  input  1  in_data/in_last are valid this cycle.
REQ-005 Port: in_ready  output  1  block accepts a nibble this cycle.
REQ-006 Port: in_data  input  4  nibble to accumulate.
REQ-007 Port: in_last  input  1  this nibble ends the packet.
REQ-008 Port: out_valid  output  1  result fields are valid.
REQ-009 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-010 Port: out_sum  output  4  ones'-complement sum of the packet.
REQ-011 Port: out_check  output  4  checksum, bitwise inverse of out_sum.
REQ-012 Port: out_count  output  4  number of nibbles accepted in the packet.
REQ-013 Port: out_err  output  1  packet truncated at MAX_LEN without in_last.

Function
REQ-014 The block SHALL use three states: IDLE (no nibble accepted yet), ACCUM (at least one accepted, no end seen), DONE (result held).
REQ-015 The block SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE.
REQ-016 An input transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On each input transfer, acc SHALL become ones'-complement add: t = acc + in_data (5 bits); acc = t[3:0] + t[4]; the carry of the second add is discarded.
REQ-018 The block SHALL NOT normalise 4'hF to 4'h0; both encodings of zero pass through unchanged.
REQ-019 On each input transfer, count SHALL increment by 1.
REQ-020 On a transfer in IDLE, acc SHALL be loaded as 0 + in_data under REQ-017 rules, count set to 1, and the state moves to ACCUM unless the packet ends.
REQ-021 A packet SHALL end on a transfer with in_last=1, or on the transfer that makes count equal MAX_LEN; the state then moves to DONE.
REQ-022 The block SHALL set out_err=1 only when the packet ends by reaching MAX_LEN with in_last=0; in_last=1 on the MAX_LEN-th nibble gives out_err=0.
REQ-023 The block SHALL assert out_valid in the cycle after the ending transfer (latency 1) and SHALL hold out_sum, out_check, out_count and out_err stable while out_valid=1.
REQ-024 out_check SHALL always equal ~out_sum.
REQ-025 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1; the state then returns to IDLE, acc and count clear to 0, out_valid drops and in_ready rises in the next cycle.
REQ-026 out_ready SHALL be honoured in the first cycle out_valid is high, giving a one-cycle DONE.
REQ-027 In DONE, in_valid SHALL be ignored, with no change to acc or count.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 Back-to-back packets SHALL sustain one nibble per cycle within a packet, with one bubble cycle (DONE) between packets.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL enter IDLE with acc=0, count=0, out_valid=0, out_err=0, out_sum=0, out_check=4'hF, out_count=0.
REQ-031 After reset, in_ready SHALL be 1.
REQ-032 Reset mid-packet or in DONE SHALL discard the partial or pending result with no output transfer.
REQ-033 An in_valid coincident with an active reset SHALL be ignored.

Verification
REQ-034 Bench: feed 3, then 4 with last -> out_sum=7, out_check=8, out_count=2, out_err=0, out_valid one cycle after the 2nd transfer.
REQ-035 Bench: feed 9, then 8 with last (end-around carry) -> out_sum=2, out_check=D, out_count=2.
REQ-036 Bench: feed F, then F with last -> out_sum=F, out_check=0; a single nibble 0 with last -> out_sum=0, out_check=F, out_count=1.
REQ-037 Bench: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and data A -> in_ready=0, outputs unchanged; release -> IDLE next cycle, and A is accepted from then on.
REQ-038 Bench: MAX_LEN=8, feed eight 1s with in_last=0 -> out_sum=8, out_count=8, out_err=1; the 9th nibble waits until the output transfer completes.
REQ-039 Bench: after 2 nibbles (5,6), pulse rst_n=0 for one cycle, then feed 5 with last -> out_sum=5, out_count=1, and no stale output appears.
